// File: rtl/alu_tile_pkg.sv
// Shared definitions for the 4-bit accumulator ALU tile: opcode map,
// the acc-preserving NOP encoding and the sequencer state encoding.
package alu_tile_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_LOADN = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_ADD   = 3'b111;

    // AND with all-ones keeps the accumulator and clears carry.
    localparam logic [2:0] NOP_OP   = OP_AND;
    localparam logic [3:0] NOP_DATA = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/prog_buf.sv
// Program buffer: DEPTH x 7-bit register file, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module prog_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [6:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [6:0]    rdata
);

    logic [6:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_prog_sequencer.sv
// Replays a host-loaded program onto the accumulator ALU tile one op per clock,
// then reports the final accumulator, carry and an XOR checksum of the run.
module alu_prog_sequencer
    import alu_tile_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_op,
    input  logic [3:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       alu_hold,
    output logic [1:0] alu_op,
    output logic [3:0] alu_data,
    input  logic [3:0] alu_acc,
    input  logic       alu_carry,
    output logic [3:0] result,
    output logic       result_c,
    output logic [3:0] checksum
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    rd_word;
    logic          wr_fire;
    logic          start_fire;
    logic          last_issue;

    assign wr_ready   = (state == IDLE) && (count != CNT_FULL);
    assign wr_fire    = wr_valid && wr_ready;
    // A write in the same cycle wins over start.
    assign start_fire = start && (state == IDLE) && (count != '0) && !wr_fire;
    assign last_issue = ({1'b0, rd_ptr} == (count - 1'b1));
    assign busy       = (state != IDLE);

    prog_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata ({wr_op, wr_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx                  = state;
        {alu_hold, alu_op}        = NOP_OP;
        alu_data                  = NOP_DATA;
        case (state)
            IDLE: begin
                if (start_fire) state_nx = RUN;
            end
            RUN: begin
                {alu_hold, alu_op} = rd_word[6:4];
                alu_data           = rd_word[3:0];
                if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            checksum <= '0;
            result   <= '0;
            result_c <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (state == IDLE) begin
                if (start_fire) begin
                    rd_ptr   <= '0;
                    checksum <= '0;
                end
            end else if (state == RUN) begin
                rd_ptr <= rd_ptr + 1'b1;
                // alu_acc reflects the previous slot; nothing issued before slot 0.
                if (rd_ptr != '0) checksum <= checksum ^ alu_acc;
            end else if (state == DRAIN) begin
                result   <= alu_acc;
                result_c <= alu_carry;
                checksum <= checksum ^ alu_acc;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_prog_sequencer.sv
// Bench for alu_prog_sequencer with a behavioural model of the ALU tile;
// table of programs with hand-computed results plus directed corner sequences.
module tb_alu_prog_sequencer;
    import alu_tile_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_op = '0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;
    logic       busy, done;
    logic       alu_hold;
    logic [1:0] alu_op;
    logic [3:0] alu_data;
    logic [3:0] acc_m = 4'h0;
    logic       carry_m = 1'b0;
    logic [3:0] result;
    logic       result_c;
    logic [3:0] checksum;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_prog_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_op     (wr_op),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .alu_hold  (alu_hold),
        .alu_op    (alu_op),
        .alu_data  (alu_data),
        .alu_acc   (acc_m),
        .alu_carry (carry_m),
        .result    (result),
        .result_c  (result_c),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Behavioural ALU tile: registers the op presented on its pins each edge.
    always @(posedge clk) begin
        case ({alu_hold, alu_op})
            OP_LOAD:  begin acc_m <= alu_data;             carry_m <= 1'b0; end
            OP_SHR:   begin acc_m <= {1'b0, acc_m[3:1]};   carry_m <= 1'b0; end
            OP_LOADN: begin acc_m <= ~alu_data;            carry_m <= 1'b0; end
            OP_SUB:   begin acc_m <= acc_m - alu_data;     carry_m <= (acc_m >= alu_data); end
            OP_AND:   begin acc_m <= acc_m & alu_data;     carry_m <= 1'b0; end
            OP_OR:    begin acc_m <= acc_m | alu_data;     carry_m <= 1'b0; end
            OP_XOR:   begin acc_m <= acc_m ^ alu_data;     carry_m <= 1'b0; end
            default:  {carry_m, acc_m} <= {1'b0, acc_m} + {1'b0, alu_data};
        endcase
    end

    typedef struct {
        int             n;
        logic [4:0][2:0] op;
        logic [4:0][3:0] d;
        logic [3:0]     res;
        logic           rc;
        logic [3:0]     cks;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_slot(input logic [2:0] op, input logic [3:0] d);
        wr_valid = 1'b1;
        wr_op    = op;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) write_slot(v.op[i], v.d[i]);
    endtask

    // Pulses start and returns cycles from start to done (capped at 40).
    task automatic run_prog(input string tag, input logic [6:0] first_pins, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        check({tag, " busy in run"}, {31'd0, busy}, 32'd1);
        check({tag, " first pins"}, {25'd0, alu_hold, alu_op, alu_data}, {25'd0, first_pins});
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic expect_no_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, " busy stays low"}, {31'd0, busy}, 32'd0);
            check({tag, " done stays low"}, {31'd0, done}, 32'd0);
            tick();
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{n: 2, op: {OP_LOAD, OP_LOAD, OP_LOAD, OP_ADD, OP_LOAD},
                    d: {4'h0, 4'h0, 4'h0, 4'h3, 4'h5}, res: 4'h8, rc: 1'b0, cks: 4'hD};
        vecs[1] = '{n: 2, op: {OP_LOAD, OP_LOAD, OP_LOAD, OP_ADD, OP_LOAD},
                    d: {4'h0, 4'h0, 4'h0, 4'h9, 4'h9}, res: 4'h2, rc: 1'b1, cks: 4'hB};
        vecs[2] = '{n: 2, op: {OP_LOAD, OP_LOAD, OP_LOAD, OP_SUB, OP_LOAD},
                    d: {4'h0, 4'h0, 4'h0, 4'h5, 4'h3}, res: 4'hE, rc: 1'b0, cks: 4'hD};
        vecs[3] = '{n: 3, op: {OP_LOAD, OP_LOAD, OP_SHR, OP_SHR, OP_LOAD},
                    d: {4'h0, 4'h0, 4'h0, 4'h0, 4'hC}, res: 4'h3, rc: 1'b0, cks: 4'h9};
        vecs[4] = '{n: 5, op: {OP_LOADN, OP_XOR, OP_OR, OP_AND, OP_LOAD},
                    d: {4'h4, 4'hF, 4'h1, 4'h6, 4'hA}, res: 4'hB, rc: 1'b0, cks: 4'hC};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset wr_ready", {31'd0, wr_ready}, 32'd1);
        check("reset busy",     {31'd0, busy},     32'd0);
        check("reset done",     {31'd0, done},     32'd0);
        check("reset result",   {27'd0, result_c, result}, 32'd0);
        check("reset checksum", {28'd0, checksum}, 32'd0);
        check("reset alu pins", {25'd0, alu_hold, alu_op, alu_data}, 32'h4F);

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_reset();
            load_vec(vecs[v]);
            run_prog(tag, {vecs[v].op[0], vecs[v].d[0]}, lat);
            check({tag, " latency"},  lat, vecs[v].n + 2);
            check({tag, " result"},   {28'd0, result},   {28'd0, vecs[v].res});
            check({tag, " result_c"}, {31'd0, result_c}, {31'd0, vecs[v].rc});
            check({tag, " checksum"}, {28'd0, checksum}, {28'd0, vecs[v].cks});
            tick();
            check({tag, " done pulse"}, {31'd0, done}, 32'd0);
            check({tag, " idle pins"}, {25'd0, alu_hold, alu_op, alu_data}, 32'h4F);
        end

        // Replay without reloading: program and count are retained.
        do_reset();
        load_vec(vecs[0]);
        run_prog("replay1", 7'h05, lat);
        tick();
        run_prog("replay2", 7'h05, lat);
        check("replay latency", lat, 4);
        check("replay result",  {27'd0, result_c, result}, 32'h8);
        check("replay checksum", {28'd0, checksum}, 32'hD);

        // Fill beyond DEPTH: the ninth write is dropped.
        do_reset();
        write_slot(OP_LOAD, 4'h1);
        for (int i = 0; i < 6; i++) write_slot(OP_ADD, 4'h1);
        check("full wr_ready after 7", {31'd0, wr_ready}, 32'd1);
        write_slot(OP_ADD, 4'h1);
        check("full wr_ready after 8", {31'd0, wr_ready}, 32'd0);
        write_slot(OP_XOR, 4'hF);
        check("full wr_ready after 9", {31'd0, wr_ready}, 32'd0);
        run_prog("full", {OP_LOAD, 4'h1}, lat);
        check("full latency",  lat, 10);
        check("full result",   {27'd0, result_c, result}, 32'h8);
        check("full checksum", {28'd0, checksum}, 32'h8);

        // start with an empty program is ignored.
        do_reset();
        expect_no_start("empty");

        // Asynchronous reset in the second RUN cycle.
        do_reset();
        load_vec(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("midrun busy before rst", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun busy",     {31'd0, busy},     32'd0);
        check("midrun wr_ready", {31'd0, wr_ready}, 32'd1);
        check("midrun done",     {31'd0, done},     32'd0);
        check("midrun pins",     {25'd0, alu_hold, alu_op, alu_data}, 32'h4F);
        tick();
        rst = 1'b0;
        expect_no_start("midrun count0");
        load_vec(vecs[0]);
        run_prog("rerun", 7'h05, lat);
        check("rerun latency",  lat, 4);
        check("rerun result",   {27'd0, result_c, result}, 32'h8);
        check("rerun checksum", {28'd0, checksum}, 32'hD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
